regfile_wb_ctrl: RTL and testbench

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

---
 rtl/rf_ctrl_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 45 ++++
 rtl/regfile_wb_ctrl.sv | 130 +++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg
// Shared constants for the register-file write-back controller:
//   XLEN   - default write-data width
//   NREG   - default architectural register count
//   IDX_W  - register index width (log2 of NREG)
//   gnt_e  - arbiter grant encoding (GNT_ALU=0, GNT_LD=1)
package rf_ctrl_pkg;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int IDX_W = $clog2(NREG);

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LD  = 1'b1
  } gnt_e;

  // One-hot request/grant vector position for a grant code: bit0=ALU, bit1=LD.
  function automatic logic [1:0] gnt_onehot(gnt_e g);
    return (g == GNT_LD) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-input round-robin arbiter with a 1-bit last-grant pointer.
// Ports:
//   clk, rst_n - clock and synchronous active-low reset
//   req[1:0]   - requests (bit0 = ALU, bit1 = load)
//   accept     - the current grant was taken (handshake completed)
//   gnt[1:0]   - combinational one-hot grant
//   ptr        - last requester granted (GNT_ALU after reset)
module rr_arb2
  import rf_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt,
  output logic       ptr
);

  gnt_e ptr_q;

  // Pointer only moves when a grant is actually consumed, so a requester
  // that drops valid before being accepted does not lose its turn.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= GNT_ALU;
    end else if (accept) begin
      ptr_q <= gnt[1] ? GNT_LD : GNT_ALU;
    end
  end

  // On a tie the side that did not win last time is granted.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (ptr_q == GNT_ALU) ? gnt_onehot(GNT_LD) : gnt_onehot(GNT_ALU);
      default: gnt = 2'b00;
    endcase
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl
// Write-back controller for a register file: arbitrates ALU and load
// write-back requests onto a single registered write port and keeps a busy
// scoreboard of destinations that have been issued but not yet written.
// Ports:
//   clk, rst_n                      - clock, synchronous active-low reset
//   alu_valid/rd/wd, alu_ready      - ALU write-back request handshake
//   ld_valid/rd/wd, ld_ready        - load write-back request handshake
//   wb_we, wb_a3, wb_wd             - registered register-file write port
//   iss_valid, iss_rd, iss_ready    - destination reservation at issue
//   rs1, rs2, rs1_busy, rs2_busy    - source-operand busy queries
//   flush                           - drop all pending destinations
//   wb_err                          - sticky: write-back to a non-busy register
module regfile_wb_ctrl #(
  parameter int XLEN = rf_ctrl_pkg::XLEN,
  parameter int NREG = rf_ctrl_pkg::NREG
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_wd,
  output logic            alu_ready,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_wd,
  output logic            ld_ready,
  output logic            wb_we,
  output logic [4:0]      wb_a3,
  output logic [XLEN-1:0] wb_wd,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  output logic            iss_ready,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            flush,
  output logic            wb_err
);

  import rf_ctrl_pkg::*;

  localparam int IW = $clog2(NREG);

  logic [1:0]      req;
  logic [1:0]      gnt;
  logic            last_gnt;
  logic            accept;
  logic [4:0]      acc_rd;
  logic [XLEN-1:0] acc_wd;
  logic            acc_nonzero;
  logic            set_en;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;

  assign req = {ld_valid, alu_valid};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .accept (accept),
    .gnt    (gnt),
    .ptr    (last_gnt)
  );

  // Readies are gated by reset so nothing is accepted while rst_n is low.
  assign alu_ready = gnt[0] & rst_n;
  assign ld_ready  = gnt[1] & rst_n;
  assign accept    = (alu_valid & alu_ready) | (ld_valid & ld_ready);

  assign acc_rd      = gnt[1] ? ld_rd : alu_rd;
  assign acc_wd      = gnt[1] ? ld_wd : alu_wd;
  assign acc_nonzero = accept && (acc_rd != 5'd0);

  assign iss_ready = rst_n & ((iss_rd == 5'd0) | ~busy[iss_rd[IW-1:0]]);
  assign set_en    = iss_valid & iss_ready & (iss_rd != 5'd0) & ~flush;

  assign rs1_busy = busy[rs1[IW-1:0]];
  assign rs2_busy = busy[rs2[IW-1:0]];

  // Clear then set, so a set wins a same-register collision; flush wipes
  // everything. Register 0 can never become busy.
  always_comb begin
    busy_next = busy;
    if (acc_nonzero) begin
      busy_next[acc_rd[IW-1:0]] = 1'b0;
    end
    if (set_en) begin
      busy_next[iss_rd[IW-1:0]] = 1'b1;
    end
    if (flush) begin
      busy_next = '0;
    end
    busy_next[0] = 1'b0;
  end

  // Write port register, scoreboard and sticky error flag. A write to x0
  // still completes its handshake but never raises wb_we.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_we  <= 1'b0;
      wb_a3  <= 5'd0;
      wb_wd  <= '0;
      busy   <= '0;
      wb_err <= 1'b0;
    end else begin
      wb_we <= acc_nonzero;
      if (accept) begin
        wb_a3 <= acc_rd;
        wb_wd <= acc_wd;
      end
      busy <= busy_next;
      if (acc_nonzero && !busy[acc_rd[IW-1:0]]) begin
        wb_err <= 1'b1;
      end
    end
  end

  // Issue and write-back to the same register in one cycle should never
  // happen; a tie must also always go to the side that did not win last.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(set_en && acc_nonzero && (iss_rd == acc_rd)));
      assert ((req != 2'b11) || gnt[~last_gnt]);
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl
// Scoreboard bench for regfile_wb_ctrl: directed scenarios followed by
// random traffic, checked against a behavioural model of the controller.
module tb_regfile_wb_ctrl;

  logic        clk;
  logic        rst_n;
  logic        alu_valid, ld_valid, iss_valid, flush;
  logic [4:0]  alu_rd, ld_rd, iss_rd, rs1, rs2;
  logic [31:0] alu_wd, ld_wd;
  logic        alu_ready, ld_ready, iss_ready, rs1_busy, rs2_busy;
  logic        wb_we, wb_err;
  logic [4:0]  wb_a3;
  logic [31:0] wb_wd;

  regfile_wb_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_wd(ld_wd), .ld_ready(ld_ready),
    .wb_we(wb_we), .wb_a3(wb_a3), .wb_wd(wb_wd),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .flush(flush), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } wr_t;

  wr_t       exp_q[$];
  int        checks   = 0;
  int        failures = 0;
  bit [31:0] m_busy   = '0;
  bit        m_err    = 1'b0;
  int        m_last   = 0;
  int        last_win = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, compare combinational outputs to the model,
  // then advance the model as of the coming rising edge.
  task automatic apply_stimulus(input bit rst, input bit av, input logic [4:0] ar,
                                input logic [31:0] aw, input bit lv, input logic [4:0] lr,
                                input logic [31:0] lw, input bit iv, input logic [4:0] ir,
                                input bit fl, input logic [4:0] r1, input logic [4:0] r2);
    int   win;
    bit   e_iss;
    logic [4:0]  rd;
    logic [31:0] wd;
    wr_t  w;
    @(negedge clk);
    rst_n = rst; alu_valid = av; alu_rd = ar; alu_wd = aw;
    ld_valid = lv; ld_rd = lr; ld_wd = lw;
    iss_valid = iv; iss_rd = ir; flush = fl; rs1 = r1; rs2 = r2;
    #1;
    last_win = -1;
    if (!rst) begin
      check("rst_alu_ready", alu_ready, 0);
      check("rst_ld_ready", ld_ready, 0);
      check("rst_iss_ready", iss_ready, 0);
      m_busy = '0; m_err = 1'b0; m_last = 0;
    end else begin
      win = -1;
      if (av && lv) win = (m_last == 0) ? 1 : 0;
      else if (av)  win = 0;
      else if (lv)  win = 1;
      e_iss = (ir == 5'd0) || !m_busy[ir];
      check("alu_ready", alu_ready, (win == 0));
      check("ld_ready", ld_ready, (win == 1));
      check("iss_ready", iss_ready, e_iss);
      check("rs1_busy", rs1_busy, m_busy[r1]);
      check("rs2_busy", rs2_busy, m_busy[r2]);
      check("wb_err", wb_err, m_err);
      if (win >= 0) begin
        rd = (win == 1) ? lr : ar;
        wd = (win == 1) ? lw : aw;
        if (rd != 5'd0) begin
          w.rd = rd; w.wd = wd;
          exp_q.push_back(w);
          if (!m_busy[rd]) m_err = 1'b1;
          m_busy[rd] = 1'b0;
        end
        m_last   = win;
        last_win = win;
      end
      if (fl) m_busy = '0;
      else if (iv && e_iss && ir != 5'd0) m_busy[ir] = 1'b1;
    end
  endtask

  task automatic idle(input int n, input logic [4:0] r1, input logic [4:0] r2);
    for (int i = 0; i < n; i++)
      apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  task automatic do_reset();
    apply_stimulus(0, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2, 1, 5'd5, 0, 0, 0);
    apply_stimulus(0, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2, 1, 5'd5, 0, 0, 0);
  endtask

  // Monitor: every write presented on the port must match the oldest
  // expected write.
  always @(posedge clk) begin
    #1;
    if (wb_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected_write", wb_we, 0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wb_a3", wb_a3, e.rd);
        check("wb_wd", wb_wd, e.wd);
      end
    end
  end

  task automatic check_output();
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    bit [3:0] rr_exp;
    rst_n = 0; alu_valid = 0; ld_valid = 0; iss_valid = 0; flush = 0;
    alu_rd = 0; ld_rd = 0; iss_rd = 0; rs1 = 0; rs2 = 0; alu_wd = 0; ld_wd = 0;

    // Reset state
    do_reset();
    idle(1, 0, 0);
    check("reset_wb_we", wb_we, 0);
    check("reset_wb_a3", wb_a3, 0);
    check("reset_wb_wd", wb_wd, 0);
    check("reset_wb_err", wb_err, 0);

    // Basic write path
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1, 5'd5, 0, 5'd5, 0);
    apply_stimulus(1, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 5'd5, 0);
    check("basic_alu_ready", alu_ready, 1);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 0);
    check("basic_wb_we", wb_we, 1);
    check("basic_busy5_clear", rs1_busy, 0);

    // Round-robin fairness after reset
    do_reset();
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1, 5'd1, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1, 5'd2, 0, 0, 0);
    rr_exp = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1, 1, 5'd1, 32'hA000 + k, 1, 5'd2, 32'hB000 + k, 0, 0, 0, 0, 0);
      check("rr_ld_grant", ld_ready, rr_exp[k]);
      check("rr_winner", last_win, rr_exp[k] ? 1 : 0);
    end

    // Issue stall on a pending destination
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 5'd7, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 5'd7, 0);
    check("stall_iss_ready", iss_ready, 0);
    check("stall_rs1_busy", rs1_busy, 1);

    // Write-back to x0
    do_reset();
    apply_stimulus(1, 0, 0, 0, 1, 5'd0, 32'h1234, 0, 0, 0, 0, 0);
    check("x0_ld_ready", ld_ready, 1);
    idle(1, 0, 0);
    check("x0_wb_we", wb_we, 0);
    check("x0_wb_err", wb_err, 0);

    // Error flag on write-back to a non-busy register
    apply_stimulus(1, 0, 0, 0, 1, 5'd9, 32'h99, 0, 0, 0, 0, 0);
    idle(1, 0, 0);
    check("err_write_we", wb_we, 1);
    check("err_set", wb_err, 1);
    idle(10, 0, 0);
    check("err_sticky", wb_err, 1);

    // Flush with a same-cycle issue
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1, 5'd3, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1, 5'd4, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1, 5'd6, 1, 5'd3, 5'd4);
    check("flush_pre_busy3", rs1_busy, 1);
    check("flush_pre_busy4", rs2_busy, 1);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd6);
    check("flush_busy3", rs1_busy, 0);
    check("flush_busy6", rs2_busy, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd4, 5'd0);
    check("flush_busy4", rs1_busy, 0);

    // Reset in the middle of a handshake
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1, 5'd8, 0, 0, 0);
    apply_stimulus(0, 1, 5'd8, 32'h5555, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 5'd8, 0);
    check("midrst_wb_we", wb_we, 0);
    check("midrst_busy8", rs1_busy, 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      bit av, lv, iv, fl;
      logic [4:0] ar, lr, ir;
      av = ($urandom_range(0, 2) != 0);
      lv = ($urandom_range(0, 2) != 0);
      iv = ($urandom_range(0, 1) != 0);
      fl = ($urandom_range(0, 15) == 0);
      ar = 5'($urandom_range(0, 31));
      lr = 5'($urandom_range(0, 31));
      ir = 5'($urandom_range(0, 31));
      if ((av && ir == ar) || (lv && ir == lr)) iv = 0;
      apply_stimulus(1, av, ar, $urandom, lv, lr, $urandom, iv, ir, fl,
                     5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    idle(3, 0, 0);
    check_output();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
